// File: rtl/debug_mem_dumper_pkg.sv
// debug_mem_dumper_pkg: shared constants and helpers for the data-memory dump reader.
// Revision: 1.0
`default_nettype none

package debug_mem_dumper_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Byte 0 is the most significant byte so words go out big-endian on the UART.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper: walks every data-memory word over the debug port and streams it as 4 bytes to uart_tx.
// Revision: 1.0
`default_nettype none

module debug_mem_dumper
    import debug_mem_dumper_pkg::*;
#(
    parameter int TAM_DATA     = 32,
    parameter int NUM_DIREC    = 7,
    parameter int NUM_WORDS    = 2**NUM_DIREC,
    parameter int READ_LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [TAM_DATA-1:0]  i_debug_read,
    input  logic                 i_tx_done,
    output logic [NUM_DIREC-1:0] o_debug_pointer,
    output logic [BYTE_W-1:0]    o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [1:0]           C_LAT       = 2'(READ_LATENCY);
    localparam logic [NUM_DIREC-1:0] C_LAST_WORD = NUM_DIREC'(NUM_WORDS - 1);

    logic [2:0]           state_q, state_d;
    logic [NUM_DIREC-1:0] ptr_q, ptr_d;
    logic [1:0]           lat_q, lat_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [31:0]          word_q, word_d;
    logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    ptr_d   = '0;
                    lat_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (lat_q == C_LAT) begin
                    state_d = S_LATCH;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_LATCH: begin
                word_d  = i_debug_read[31:0];
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    if (cnt_q == 2'd3) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (ptr_q == C_LAST_WORD) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    lat_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                ptr_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each one lines up with the state it belongs to.
    always_comb begin
        tx_start_d = (state_d == S_SEND);
        tx_data_d  = (state_d == S_SEND) ? word_byte(word_d, cnt_d) : tx_data_q;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            lat_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lat_q      <= lat_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_debug_pointer = ptr_q;
    assign o_tx_data       = tx_data_q;
    assign o_tx_start      = tx_start_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

`default_nettype wire
